// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The WB-stage pipe always owns the port
// when it writes; divider results wait in a 2-entry queue and drain into
// pipe bubbles. A starvation counter raises wb_hold to ask upstream for a
// bubble when the queue has been denied for STARVE_LIMIT cycles.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        div_valid,
  input  logic [4:0]  div_waddr,
  input  logic [31:0] div_wdata,
  output logic        div_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_src,
  output logic        wb_hold,
  output logic [31:0] pend_mask
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]  q_waddr [2];
  logic [31:0] q_wdata [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic [3:0]  starve;

  logic        pipe_win;
  logic        push;
  logic        pop;
  logic [1:0]  count_next;
  logic [3:0]  starve_next;

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle. Results to r0 are accepted but not queued.
  assign div_ready = (count != 2'd2);
  assign push      = div_valid && div_ready && (div_waddr != 5'd0);
  // Reset also masks the pipe so the port is quiet for the whole reset pulse.
  assign pipe_win  = !reset && pipe_valid && pipe_we && (pipe_waddr != 5'd0);
  assign pop       = !pipe_win && (count != 2'd0);

  // Next occupancy and next starvation count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_next  = count;
    starve_next = starve;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
    if (pop || count == 2'd0)
      starve_next = 4'd0;
    else if (pipe_win && starve != LIMIT)
      starve_next = starve + 4'd1;
  end

  // Port mux: pipe first, then queue head, otherwise idle with zeroed fields.
  always_comb begin
    rf_we    = 1'b0;
    rf_src   = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pipe_win) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else if (count != 2'd0) begin
      rf_we    = 1'b1;
      rf_src   = 1'b1;
      rf_waddr = q_waddr[head];
      rf_wdata = q_wdata[head];
    end
  end

  // Pending-destination mask for the ID hazard check, from queue state only.
  always_comb begin
    pend_mask = 32'd0;
    if (count != 2'd0)
      pend_mask = pend_mask | (32'd1 << q_waddr[head]);
    if (count == 2'd2)
      pend_mask = pend_mask | (32'd1 << q_waddr[~head]);
  end

  // Queue control, starvation counter and hold request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      starve  <= 4'd0;
      wb_hold <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      count  <= count_next;
      starve <= starve_next;
      if (push)
        tail <= ~tail;
      if (pop)
        head <= ~head;
      if (pop)
        wb_hold <= 1'b0;
      else if (starve_next == LIMIT)
        wb_hold <= 1'b1;
    end
  end

  // Queue payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; count gates every read, so stale
    // contents are never observed after reset.
    if (push) begin
      q_waddr[tail] <= div_waddr;
      q_wdata[tail] <= div_wdata;
    end
  end

endmodule
